// File: rtl/ps2_key_event_fifo.sv
// PS/2 Set-2 scancode decoder feeding a first-word-fall-through key event FIFO.
// Events are {brk, ext, code}; the CPU reads the head through the packed o_gpio word.
//
// state | meaning
// IDLE  | waiting for a code, prefix or Pause lead-in byte
// PFX   | E0 and/or F0 seen; ext/brk hold the prefix flags
// PAUSE | swallowing the rest of the 8-byte Pause sequence
module ps2_key_event_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [7:0]               i_scan_data,
  input  logic                     i_scan_valid,
  input  logic                     i_pop,
  input  logic                     i_clr_ovf,
  output logic [9:0]               o_evt,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow,
  output logic [15:0]              o_gpio
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  typedef enum logic [1:0] {IDLE, PFX, PAUSE} state_t;

  state_t     state;
  logic       ext;
  logic       brk;
  logic [2:0] skip_cnt;

  logic       evt_vld;
  logic [9:0] evt_data;

  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          overflow;
  logic          full;
  logic          empty;
  logic          do_push;
  logic          do_pop;

  function automatic logic is_status(input logic [7:0] b);
    return (b == 8'h00) || (b == 8'hAA) || (b == 8'hEE) ||
           (b == 8'hFA) || (b == 8'hFE) || (b == 8'hFF);
  endfunction

  // Event emission is decoded from the current state and incoming byte so the
  // FIFO write lands on the same edge that samples the final byte.
  always_comb begin
    evt_vld  = 1'b0;
    evt_data = {brk, ext, i_scan_data};
    if (i_scan_valid) begin
      unique case (state)
        IDLE: evt_vld = !(i_scan_data == 8'hE0 || i_scan_data == 8'hF0 ||
                          i_scan_data == 8'hE1 || is_status(i_scan_data));
        PFX:  evt_vld = !(i_scan_data == 8'hE0 || i_scan_data == 8'hF0);
        PAUSE: begin
          evt_vld  = (skip_cnt == 3'd1);
          evt_data = 10'h1E1;
        end
        default: evt_vld = 1'b0;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      ext      <= 1'b0;
      brk      <= 1'b0;
      skip_cnt <= 3'd0;
    end else if (i_scan_valid) begin
      unique case (state)
        IDLE, PFX: begin
          if (i_scan_data == 8'hE0) begin
            ext   <= 1'b1;
            state <= PFX;
          end else if (i_scan_data == 8'hF0) begin
            brk   <= 1'b1;
            state <= PFX;
          end else if (state == IDLE && i_scan_data == 8'hE1) begin
            skip_cnt <= 3'd7;
            state    <= PAUSE;
          end else if (state == IDLE && is_status(i_scan_data)) begin
            state <= IDLE;
          end else begin
            ext   <= 1'b0;
            brk   <= 1'b0;
            state <= IDLE;
          end
        end
        PAUSE: begin
          skip_cnt <= skip_cnt - 3'd1;
          if (skip_cnt == 3'd1) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = i_pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_push = evt_vld && (!full || do_pop);

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= evt_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (evt_vld && !do_push) overflow <= 1'b1;
      else if (i_clr_ovf)      overflow <= 1'b0;
    end
  end

  // Masked while empty so the uninitialised RAM never shows up on the outputs.
  assign o_evt      = empty ? 10'h000 : mem[rd_ptr];
  assign o_empty    = empty;
  assign o_count    = count;
  assign o_overflow = overflow;
  assign o_gpio     = {~empty, overflow, 4'b0000, o_evt};

endmodule
